// File: rtl/vga_pkg.sv
// VGA 640x480@60 raster constants and the per-axis phase encoding,
// shared by the timing generator, bitGen and the glyph blocks.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_PIX_DIV = 2;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    // Gray-ordered: each phase step flips one bit, so sync/blank decodes
    // of the phase register do not glitch at a transition.
    typedef enum logic [1:0] {
        PH_VIS  = 2'b00,
        PH_FP   = 2'b01,
        PH_SYNC = 2'b11,
        PH_BP   = 2'b10
    } phase_e;

    function automatic int axis_total(int vis, int fp, int sync, int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL =
        axis_total(VGA_H_VIS, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL =
        axis_total(VGA_V_VIS, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel generator,
// glyph logic and the connector sync pins.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic             pixelClk;
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             bright;
    logic             hSync;
    logic             vSync;
    logic             lineStart;
    logic             frameStart;

    modport master (
        output pixelClk,
        output hCount,
        output vCount,
        output bright,
        output hSync,
        output vSync,
        output lineStart,
        output frameStart
    );

    modport slave (
        input pixelClk,
        input hCount,
        input vCount,
        input bright,
        input hSync,
        input vSync,
        input lineStart,
        input frameStart
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus VIS -> FP -> SYNC -> BP phase FSM.
// Count and phase are loaded from the same next value on one edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VIS  = VGA_H_VIS,
    parameter int FP   = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP   = VGA_H_BP
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output logic             wrap
);

    localparam int TOTAL = axis_total(VIS, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_AT   = CNT_W'(VIS);
    localparam logic [CNT_W-1:0] SYNC_AT = CNT_W'(VIS + FP);
    localparam logic [CNT_W-1:0] BP_AT   = CNT_W'(VIS + FP + SYNC);

    logic [CNT_W-1:0] count_next;
    phase_e           phase_next;

    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
            phase <= PH_VIS;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        count_next = count;
        phase_next = phase;
        if (advance) begin
            count_next = wrap ? '0 : count + CNT_W'(1);
            unique case (phase)
                PH_VIS: begin
                    if (count_next == FP_AT)
                        phase_next = PH_FP;
                end
                PH_FP: begin
                    if (count_next == SYNC_AT)
                        phase_next = PH_SYNC;
                end
                PH_SYNC: begin
                    if (count_next == BP_AT)
                        phase_next = PH_BP;
                end
                PH_BP: begin
                    if (wrap)
                        phase_next = PH_VIS;
                end
                default: phase_next = PH_VIS;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-strobe divider, horizontal and vertical
// axis counters, and the registered line/frame start pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = VGA_PIX_DIV,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic             clk,
    input  logic             clr_n,
    vga_timing_gen_if.master vga
);

    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0]       div;
    logic             tick;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_e           h_phase;
    phase_e           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             pix_q;
    logic             line_q;
    logic             frame_q;

    // With PIX_DIV=1 DIV_LAST is 0, so tick holds high every clk.
    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!clr_n)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 4'd1;
    end

    vga_axis_counter #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h (
        .clk     (clk),
        .clr_n   (clr_n),
        .advance (tick),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v (
        .clk     (clk),
        .clr_n   (clr_n),
        .advance (tick & h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (v_wrap)
    );

    // Pulses are loaded on the same edge that moves the counters to 0.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pix_q   <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pix_q   <= tick;
            line_q  <= tick & h_wrap;
            frame_q <= tick & h_wrap & v_wrap;
        end
    end

    assign vga.pixelClk   = pix_q;
    assign vga.hCount     = h_count;
    assign vga.vCount     = v_count;
    assign vga.bright     = (h_phase == PH_VIS) && (v_phase == PH_VIS);
    assign vga.hSync      = (h_phase != PH_SYNC);
    assign vga.vSync      = (v_phase != PH_SYNC);
    assign vga.lineStart  = line_q;
    assign vga.frameStart = frame_q;

endmodule
